// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants and lane keep-mask helper.
package fifo_pkg;
  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;
  localparam int MAX_LANES = 32;
  function automatic logic [MAX_LANES-1:0] lanes_to_keep(input int unsigned n);
    return n >= MAX_LANES ? '1 : (MAX_LANES'(1) << n) - MAX_LANES'(1);
  endfunction
endpackage

// File: rtl/fifo_rd_upsizer_if.sv
// fifo_rd_upsizer_if: wide valid/ready beat stream with lane mask and last flag.
interface fifo_rd_upsizer_if #(parameter int DSIZE = 8, parameter int RATIO = 4);
  logic                     m_valid;
  logic                     m_ready;
  logic [DSIZE*RATIO-1:0]   m_data;
  logic [RATIO-1:0]         m_keep;
  logic                     m_last;
  modport master(output m_valid, m_data, m_keep, m_last, input m_ready);
  modport slave(input m_valid, m_data, m_keep, m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_upsizer_stream_out_reg.sv
// stream_out_reg: output beat holding register with load/hold/drain handshake.
module stream_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] ld_data,
  input  logic [KW-1:0] ld_keep,
  input  logic          ld_last,
  output logic          out_free,
  fifo_rd_upsizer_if.master m
);
  assign out_free = !m.m_valid || m.m_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_keep  <= '0;
      m.m_last  <= 1'b0;
    end else if (load) begin
      m.m_valid <= 1'b1;
      m.m_data  <= ld_data;
      m.m_keep  <= ld_keep;
      m.m_last  <= ld_last;
    end else if (m.m_ready) begin
      m.m_valid <= 1'b0;
    end
endmodule

// File: rtl/fifo_rd_upsizer.sv
// fifo_rd_upsizer: pops RATIO narrow FIFO words into one wide stream beat, with flush of partial beats.
module fifo_rd_upsizer import fifo_pkg::*; #(
  parameter int DSIZE = DSIZE_DEF,
  parameter int RATIO = 4,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  fifo_rd_upsizer_if.master m,
  output logic [CNTW-1:0]  beat_cnt,
  output logic             idle
);
  localparam int IW = $clog2(RATIO);
  localparam logic [IW-1:0] LAST = IW'(RATIO - 1);
  logic [RATIO-1:0][DSIZE-1:0] acc, ld_data;
  logic [IW-1:0] idx;
  logic flush_pend, out_free, full_load, flush_load;
  logic [MAX_LANES-1:0] keep_full, keep_part;
  assign rinc       = rrst_n && !rempty && !flush_pend && (idx != LAST || out_free);
  assign full_load  = rinc && idx == LAST;
  assign flush_load = flush_pend && idx != '0 && out_free;
  assign keep_full  = lanes_to_keep(RATIO);
  assign keep_part  = lanes_to_keep(32'(idx));
  assign idle       = idx == '0 && !m.m_valid && !flush_pend;
  // A full beat takes the completing word straight from rdata; a flush zeroes lanes not yet filled.
  always_comb begin
    ld_data = '0;
    for (int i = 0; i < RATIO; i++)
      ld_data[i] = full_load ? (i == RATIO - 1 ? rdata : acc[i]) : (i < int'(idx) ? acc[i] : '0);
  end
  stream_out_reg #(.DW(DSIZE * RATIO), .KW(RATIO)) u_out (
    .clk     (rclk),
    .rst_n   (rrst_n),
    .load    (full_load || flush_load),
    .ld_data (ld_data),
    .ld_keep (full_load ? keep_full[RATIO-1:0] : keep_part[RATIO-1:0]),
    .ld_last (!full_load),
    .out_free(out_free),
    .m       (m)
  );
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      acc        <= '0;
      idx        <= '0;
      flush_pend <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      if (rinc) acc[idx] <= rdata;
      idx        <= (full_load || flush_load) ? '0 : rinc ? idx + 1'b1 : idx;
      flush_pend <= flush_pend ? !(idx == '0 || out_free) : flush;
      beat_cnt   <= beat_cnt + CNTW'(m.m_valid && m.m_ready);
    end
endmodule

// File: tb/tb_fifo_rd_upsizer.sv
// tb_fifo_rd_upsizer: directed scenarios against a small FIFO model and beat monitor.
module tb_fifo_rd_upsizer;
  logic        rclk = 1'b0, rrst_n = 1'b0, flush = 1'b0, hide = 1'b0;
  logic        rempty, rinc, idle;
  logic [7:0]  rdata;
  logic [15:0] beat_cnt;
  logic [7:0]  mem [64];
  int          wr_ptr = 0, rd_ptr = 0, pops = 0, nb = 0;
  logic        bad_pop = 1'b0;
  logic [31:0] bdata [64];
  logic [3:0]  bkeep [64];
  logic        blast [64];
  int          checks = 0, errors = 0;

  fifo_rd_upsizer_if #(.DSIZE(8), .RATIO(4)) s();

  fifo_rd_upsizer #(.DSIZE(8), .RATIO(4), .CNTW(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .m(s), .beat_cnt(beat_cnt), .idle(idle)
  );

  always #5 rclk = ~rclk;

  assign rempty = hide || rd_ptr == wr_ptr;
  assign rdata  = mem[rd_ptr[5:0]];

  always @(posedge rclk) begin
    if (rinc) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
    if (rinc && rempty) bad_pop <= 1'b1;
    if (s.m_valid && s.m_ready) begin
      bdata[nb[5:0]] <= s.m_data;
      bkeep[nb[5:0]] <= s.m_keep;
      blast[nb[5:0]] <= s.m_last;
      nb <= nb + 1;
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic wait_nb(input int t);
    for (int i = 0; i < 100 && nb < t; i++) @(negedge rclk);
  endtask

  task automatic test_reset;
    s.m_ready = 1'b0;
    step(2);
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b want 0", rinc); end
    checks++; if (s.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", s.m_valid); end
    checks++; if (s.m_data !== 32'h0 || s.m_keep !== 4'h0 || s.m_last !== 1'b0) begin errors++; $display("FAIL reset_out got %h/%h/%b want 0/0/0", s.m_data, s.m_keep, s.m_last); end
    checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", beat_cnt); end
    rrst_n = 1'b1;
    step(1);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
  endtask

  task automatic test_full_beats;
    int base;
    base = nb;
    s.m_ready = 1'b1;
    for (int v = 1; v <= 8; v++) push(8'(v * 17));
    wait_nb(base + 2);
    step(2);
    checks++; if (nb !== base + 2) begin errors++; $display("FAIL full_nbeats got %0d want %0d", nb - base, 2); end
    checks++; if (bdata[base] !== 32'h44332211 || bkeep[base] !== 4'hF || blast[base] !== 1'b0) begin errors++; $display("FAIL full_beat0 got %h/%h/%b want 44332211/f/0", bdata[base], bkeep[base], blast[base]); end
    checks++; if (bdata[base+1] !== 32'h88776655 || bkeep[base+1] !== 4'hF || blast[base+1] !== 1'b0) begin errors++; $display("FAIL full_beat1 got %h/%h/%b want 88776655/f/0", bdata[base+1], bkeep[base+1], blast[base+1]); end
    checks++; if (beat_cnt !== 16'd2) begin errors++; $display("FAIL full_cnt got %0d want 2", beat_cnt); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL full_idle got %b want 1", idle); end
  endtask

  task automatic test_backpressure;
    int base, p0;
    base = nb;
    p0 = pops;
    s.m_ready = 1'b0;
    for (int v = 1; v <= 8; v++) push(8'(v * 17));
    step(20);
    checks++; if (pops - p0 !== 7) begin errors++; $display("FAIL bp_pops got %0d want 7", pops - p0); end
    checks++; if (rinc !== 1'b0 || rempty !== 1'b0) begin errors++; $display("FAIL bp_stall got rinc=%b rempty=%b want 0/0", rinc, rempty); end
    checks++; if (s.m_valid !== 1'b1 || s.m_data !== 32'h44332211) begin errors++; $display("FAIL bp_hold got %b/%h want 1/44332211", s.m_valid, s.m_data); end
    s.m_ready = 1'b1;
    wait_nb(base + 2);
    step(2);
    checks++; if (bdata[base] !== 32'h44332211) begin errors++; $display("FAIL bp_beat0 got %h want 44332211", bdata[base]); end
    checks++; if (bdata[base+1] !== 32'h88776655) begin errors++; $display("FAIL bp_beat1 got %h want 88776655", bdata[base+1]); end
    checks++; if (pops - p0 !== 8 || bad_pop !== 1'b0) begin errors++; $display("FAIL bp_total got pops=%0d bad=%b want 8/0", pops - p0, bad_pop); end
  endtask

  task automatic test_partial_flush;
    int base;
    base = nb;
    s.m_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3);
    step(5);
    checks++; if (idle !== 1'b0 || s.m_valid !== 1'b0) begin errors++; $display("FAIL pf_acc got idle=%b valid=%b want 0/0", idle, s.m_valid); end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    #1;
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL pf_nopop got %b want 0", rinc); end
    step(1);
    checks++; if (s.m_valid !== 1'b1 || s.m_data !== 32'h00A3A2A1 || s.m_keep !== 4'h7 || s.m_last !== 1'b1) begin errors++; $display("FAIL pf_beat got %b/%h/%h/%b want 1/00a3a2a1/7/1", s.m_valid, s.m_data, s.m_keep, s.m_last); end
    checks++; if (rinc !== 1'b1) begin errors++; $display("FAIL pf_resume got %b want 1", rinc); end
    s.m_ready = 1'b1;
    wait_nb(base + 2);
    step(2);
    checks++; if (bdata[base] !== 32'h00A3A2A1 || bkeep[base] !== 4'h7 || blast[base] !== 1'b1) begin errors++; $display("FAIL pf_acc_beat got %h/%h/%b want 00a3a2a1/7/1", bdata[base], bkeep[base], blast[base]); end
    checks++; if (bdata[base+1] !== 32'hB4B3B2B1 || bkeep[base+1] !== 4'hF || blast[base+1] !== 1'b0) begin errors++; $display("FAIL pf_next_beat got %h/%h/%b want b4b3b2b1/f/0", bdata[base+1], bkeep[base+1], blast[base+1]); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL pf_idle got %b want 1", idle); end
  endtask

  task automatic test_empty_flush;
    int base;
    base = nb;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    checks++; if (idle !== 1'b0 || s.m_valid !== 1'b0) begin errors++; $display("FAIL ef_pend got idle=%b valid=%b want 0/0", idle, s.m_valid); end
    step(1);
    checks++; if (idle !== 1'b1 || s.m_valid !== 1'b0) begin errors++; $display("FAIL ef_clear got idle=%b valid=%b want 1/0", idle, s.m_valid); end
    checks++; if (nb !== base) begin errors++; $display("FAIL ef_nobeat got %0d want 0", nb - base); end
  endtask

  task automatic test_sparse;
    int base, p0;
    base = nb;
    p0 = pops;
    s.m_ready = 1'b1;
    hide = 1'b1;
    for (int v = 1; v <= 4; v++) push(8'(v));
    for (int i = 0; i < 16; i++) begin
      @(negedge rclk);
      hide = ~hide;
      #1;
      checks++; if (rinc && rempty) begin errors++; $display("FAIL sp_gate got rinc=1 rempty=1 want rinc=0"); end
    end
    hide = 1'b0;
    wait_nb(base + 1);
    step(2);
    checks++; if (bdata[base] !== 32'h04030201 || bkeep[base] !== 4'hF) begin errors++; $display("FAIL sp_beat got %h/%h want 04030201/f", bdata[base], bkeep[base]); end
    checks++; if (pops - p0 !== 4 || bad_pop !== 1'b0) begin errors++; $display("FAIL sp_pops got %0d bad=%b want 4/0", pops - p0, bad_pop); end
  endtask

  task automatic test_reset_mid;
    int base;
    s.m_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h99); push(8'h9A);
    step(12);
    checks++; if (s.m_valid !== 1'b1 || idle !== 1'b0) begin errors++; $display("FAIL rm_pre got valid=%b idle=%b want 1/0", s.m_valid, idle); end
    rrst_n = 1'b0;
    #1;
    checks++; if (s.m_valid !== 1'b0 || rinc !== 1'b0 || beat_cnt !== 16'd0) begin errors++; $display("FAIL rm_async got valid=%b rinc=%b cnt=%0d want 0/0/0", s.m_valid, rinc, beat_cnt); end
    step(1);
    rrst_n = 1'b1;
    base = nb;
    for (int v = 5; v <= 8; v++) push(8'(v * 17));
    s.m_ready = 1'b1;
    wait_nb(base + 1);
    step(1);
    checks++; if (bdata[base] !== 32'h88776655 || bkeep[base] !== 4'hF || blast[base] !== 1'b0) begin errors++; $display("FAIL rm_beat got %h/%h/%b want 88776655/f/0", bdata[base], bkeep[base], blast[base]); end
    checks++; if (beat_cnt !== 16'd1) begin errors++; $display("FAIL rm_cnt got %0d want 1", beat_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_full_beats;
    test_backpressure;
    test_partial_flush;
    test_empty_flush;
    test_sparse;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_upsizer.md
Name: fifo_rd_upsizer

Overview:
- Read-side consumer of the team's async FIFO. Runs entirely in the read clock domain.
- Pops DSIZE-bit words via rinc/rempty/rdata and packs RATIO consecutive words into one wide beat.
- Presents each beat on a valid/ready master stream.
- A flush request emits a partial beat with a lane mask, so short trailing data is never stranded.

Parameters:
- DSIZE, 8: FIFO word width in bits. Must match the FIFO's DSIZE.
- RATIO, 4: words per output beat. Must be >= 2.
- CNTW, 16: width of the emitted-beat counter.

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  asynchronous active-low reset.
- rempty  in  1  FIFO empty flag.
- rdata  in  DSIZE  FIFO read data. Valid combinationally whenever rempty=0.
- rinc  out  1  FIFO pop strobe. Combinational.
- flush  in  1  single-cycle request to emit the current partial beat.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  DSIZE*RATIO  packed beat. Lane 0 (LSBs) holds the first word popped.
- m_keep  out  RATIO  per-lane valid mask.
- m_last  out  1  beat was produced by a flush.
- beat_cnt  out  CNTW  count of beats accepted (m_valid && m_ready). Wraps modulo 2^CNTW.
- idle  out  1  idx==0 && !m_valid && !flush_pend.

Behaviour:
- State:
  - accumulator acc[RATIO] and lane index idx (0..RATIO-1).
  - output register: out_data, out_keep, out_last, m_valid.
  - flag flush_pend; counter beat_cnt.
- Reset (rrst_n low, asynchronous): idx=0, acc=0, m_valid=0, m_data=0, m_keep=0, m_last=0, flush_pend=0, beat_cnt=0.
  - rinc is gated by rrst_n, so it is 0 during reset.
  - Reset mid-beat discards the partial accumulator and any held output beat.
- out_free = !m_valid || m_ready.
- Pop rule: rinc = rrst_n && !rempty && !flush_pend && (idx != RATIO-1 || out_free). rinc is never 1 while rempty=1.
- On a rising edge with rinc=1:
  - rdata is written to acc[idx].
  - If idx < RATIO-1: idx increments.
  - If idx == RATIO-1: the beat {rdata, acc[RATIO-2..0]} loads the output register, keep = all ones, last = 0, m_valid=1, idx=0.
- Latency: the word completing a beat is popped at edge N; m_valid is high from edge N through at least the next edge.
- Output hold: while m_valid && !m_ready, m_data, m_keep and m_last are stable.
  - On m_valid && m_ready with no new load, m_valid drops to 0.
  - Load and drain in the same cycle gives back-to-back beats.
- Flush:
  - A flush pulse sets flush_pend. Repeated pulses while pending are absorbed.
  - A pop in the same cycle as the flush pulse still happens and is included in the partial beat.
  - While flush_pend=1, popping stops.
  - When flush_pend && idx != 0 && out_free: the output loads acc lanes 0..idx-1, with unfilled lanes zero, keep = (1<<idx)-1, last = 1. Then idx=0 and flush_pend=0.
  - When flush_pend && idx == 0: flush_pend clears with no beat emitted.
- beat_cnt increments on each m_valid && m_ready handshake and wraps to 0 after 2^CNTW-1.

Decomposition:
- Shared package fifo_pkg holds:
  - DSIZE_DEF and ASIZE_DEF constants.
  - a keep-mask helper function lanes_to_keep(idx).
- One natural sub-module, stream_out_reg: the output holding register with the load/hold/drain handshake and m_valid.
- The accumulator, index, pop rule and flush logic stay in the top.

Test Plan:
1. Full beats, no stall: FIFO supplies 0x11,0x22,...,0x88 with m_ready=1.
   - Response: two beats, 0x44332211 then 0x88776655, keep=0xF, last=0; beat_cnt=2; idle=1 afterwards.
2. Backpressure: 8 words available, m_ready=0 from start.
   - Response: exactly 7 pops, then rinc=0 while rempty=0. m_data holds 0x44332211 stable.
   - Raising m_ready gives the second beat 0x88776655 on the next load.
3. Partial flush: pop 0xA1,0xA2,0xA3, then pulse flush with rempty=1.
   - Response: m_data=0x00A3A2A1, keep=0x7, last=1.
   - With more words then present, rinc stays 0 until that beat loads.
4. Flush with nothing to emit: pulse flush with idx=0 and no output beat.
   - Response: no m_valid; flush_pend clears next cycle; idle=1.
5. Sparse source: rempty toggles every cycle across 4 words 0x01..0x04.
   - Response: rinc only when rempty=0; one beat 0x04030201, keep=0xF.
6. Reset mid-operation: 2 words accumulated plus one held output beat, then rrst_n low for 1 cycle.
   - Response: m_valid, rinc and beat_cnt all 0 immediately.
   - The next 4 words 0x55..0x88 form a clean beat 0x88776655.
